// File: rtl/dijkstra_path_engine.sv
// Dijkstra route planner: sequential INIT/SCAN/RELAX over a combinational map ROM,
// traces the prev chain into a path buffer read back by index.
module dijkstra_path_engine #(
  parameter int         NODES   = 30,
  parameter int         MAX_DEG = 4,
  parameter logic [7:0] INF     = 8'hFF
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       CPU_start,
  input  logic [4:0] start_point,
  input  logic [4:0] end_point,
  output logic [4:0] rom_addr,
  output logic [1:0] rom_slot,
  input  logic [4:0] rom_nbr,
  input  logic [3:0] rom_wt,
  input  logic [4:0] path_idx,
  output logic [4:0] path_node,
  output logic [4:0] path_len,
  output logic       path_valid,
  output logic       busy,
  output logic       no_path
);
  typedef enum logic [2:0] {IDLE, INIT, SCAN, RELAX, TRACE, FAIL, HOLD} state_e;
  localparam logic [4:0] LAST_N = 5'(NODES - 1);
  localparam logic [4:0] LAST_K = 5'(MAX_DEG - 1);

  state_e           state_q, state_d;
  logic             cpu_q, busy_q, valid_q, nopath_q;
  logic [4:0]       src_q, dst_q, cnt_q, u_q, cur_q, n_q, len_q;
  logic [7:0]       best_q;
  logic [7:0]       dist_q [NODES];
  logic [4:0]       prev_q [NODES];
  logic [4:0]       pbuf_q [NODES];
  logic [NODES-1:0] vis_q;

  logic       trig, bad_ep, scan_take, relax_upd, abort;
  logic [7:0] scan_best;
  logic [4:0] scan_u;
  logic [8:0] sum;

  // start_point alone never retriggers: the planner tracks its position on it
  assign trig   = CPU_start & (~cpu_q | (end_point != dst_q));
  assign bad_ep = (start_point > LAST_N) | (end_point > LAST_N);
  assign abort  = ~CPU_start & (state_q inside {INIT, SCAN, RELAX, TRACE});

  // running minimum; strict compare in ascending order keeps ties on the lower id
  assign scan_take = ~vis_q[cnt_q] & (dist_q[cnt_q] < best_q);
  assign scan_best = scan_take ? dist_q[cnt_q] : best_q;
  assign scan_u    = scan_take ? cnt_q : u_q;

  assign sum       = {1'b0, dist_q[u_q]} + {5'd0, rom_wt};
  assign relax_upd = (rom_wt != 4'd0) & (rom_nbr <= LAST_N) & ~vis_q[rom_nbr] &
                     (sum < {1'b0, INF}) & (sum[7:0] < dist_q[rom_nbr]);

  assign rom_addr   = (state_q == RELAX) ? u_q : 5'd0;
  assign rom_slot   = (state_q == RELAX) ? cnt_q[1:0] : 2'd0;
  assign path_len   = len_q;
  assign path_node  = (path_idx < len_q) ? pbuf_q[len_q - 5'd1 - path_idx] : 5'd0;
  assign path_valid = valid_q;
  assign busy       = busy_q;
  assign no_path    = nopath_q;

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (trig) state_d = bad_ep ? FAIL : INIT;
    else if (abort) state_d = IDLE;
    else begin
      case (state_q)
        INIT:  if (cnt_q == LAST_N) state_d = SCAN;
        SCAN:  if (cnt_q == LAST_N)
                 state_d = (scan_best == INF) ? FAIL : (scan_u == dst_q) ? TRACE : RELAX;
        RELAX: if (cnt_q == LAST_K) state_d = SCAN;
        TRACE: if (cur_q == src_q) state_d = HOLD;
        FAIL:  state_d = HOLD;
        HOLD:  if (!CPU_start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      cpu_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      nopath_q <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      u_q      <= '0;
      cur_q    <= '0;
      n_q      <= '0;
      len_q    <= '0;
      best_q   <= INF;
      vis_q    <= '0;
      for (int i = 0; i < NODES; i++) begin
        dist_q[i] <= '0;
        prev_q[i] <= '0;
        pbuf_q[i] <= '0;
      end
    end else begin
      cpu_q <= CPU_start;
      if (trig) begin
        src_q    <= start_point;
        dst_q    <= end_point;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        valid_q  <= 1'b0;
        nopath_q <= 1'b0;
        len_q    <= '0;
      end else if (abort) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          INIT: begin
            dist_q[cnt_q] <= (cnt_q == src_q) ? 8'd0 : INF;
            prev_q[cnt_q] <= cnt_q;
            vis_q[cnt_q]  <= 1'b0;
            cnt_q         <= (cnt_q == LAST_N) ? 5'd0 : cnt_q + 5'd1;
            best_q        <= INF;
          end
          SCAN: begin
            best_q <= scan_best;
            u_q    <= scan_u;
            cnt_q  <= (cnt_q == LAST_N) ? 5'd0 : cnt_q + 5'd1;
            if (cnt_q == LAST_N && scan_best != INF) begin
              if (scan_u == dst_q) begin
                cur_q <= dst_q;
                n_q   <= '0;
              end else begin
                vis_q[scan_u] <= 1'b1;
              end
            end
          end
          RELAX: begin
            if (relax_upd) begin
              dist_q[rom_nbr] <= sum[7:0];
              prev_q[rom_nbr] <= u_q;
            end
            cnt_q <= (cnt_q == LAST_K) ? 5'd0 : cnt_q + 5'd1;
            if (cnt_q == LAST_K) best_q <= INF;
          end
          TRACE: begin
            pbuf_q[n_q] <= cur_q;
            if (cur_q == src_q) begin
              len_q   <= n_q + 5'd1;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cur_q <= prev_q[cur_q];
              n_q   <= n_q + 5'd1;
            end
          end
          FAIL: begin
            nopath_q <= 1'b1;
            busy_q   <= 1'b0;
            len_q    <= '0;
          end
          HOLD: if (!CPU_start) valid_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dijkstra_path_engine.sv
// Bench for dijkstra_path_engine: directed planner scenarios plus random graphs
// checked against a Bellman-Ford shortest-cost model.
module tb_dijkstra_path_engine;
  localparam int N = 30;

  logic       clk = 1'b0, rst_n = 1'b0, CPU_start = 1'b0;
  logic [4:0] start_point = '0, end_point = '0, path_idx = '0;
  logic [4:0] rom_addr, rom_nbr, path_node, path_len;
  logic [1:0] rom_slot;
  logic [3:0] rom_wt;
  logic       path_valid, busy, no_path;

  logic [4:0] nbr_tab [32][4];
  logic [3:0] wt_tab  [32][4];

  int n_cmp = 0, n_bad = 0;
  int cyc;
  bit busy_gap;

  always #5 clk = ~clk;

  assign rom_nbr = nbr_tab[rom_addr][rom_slot];
  assign rom_wt  = wt_tab[rom_addr][rom_slot];

  dijkstra_path_engine dut (
    .clk_3125KHz(clk), .rst_n(rst_n), .CPU_start(CPU_start),
    .start_point(start_point), .end_point(end_point),
    .rom_addr(rom_addr), .rom_slot(rom_slot), .rom_nbr(rom_nbr), .rom_wt(rom_wt),
    .path_idx(path_idx), .path_node(path_node), .path_len(path_len),
    .path_valid(path_valid), .busy(busy), .no_path(no_path)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic clr_rom(input bit rnd_fill);
    for (int a = 0; a < 32; a++)
      for (int k = 0; k < 4; k++) begin
        nbr_tab[a][k] = rnd_fill ? 5'($urandom_range(0, 31)) : 5'd0;
        wt_tab[a][k]  = 4'd0;
      end
  endtask

  function automatic int free_slot(input int a);
    for (int k = 0; k < 4; k++) if (wt_tab[a][k] == 4'd0) return k;
    return -1;
  endfunction

  function automatic int edge_w(input int a, input int b);
    for (int k = 0; k < 4; k++)
      if (wt_tab[a][k] != 4'd0 && int'(nbr_tab[a][k]) == b) return int'(wt_tab[a][k]);
    return 0;
  endfunction

  task automatic add_edge(input int a, input int b, input int w);
    int ka, kb;
    ka = free_slot(a);
    kb = free_slot(b);
    if (ka >= 0 && kb >= 0) begin
      nbr_tab[a][ka] = 5'(b); wt_tab[a][ka] = 4'(w);
      nbr_tab[b][kb] = 5'(a); wt_tab[b][kb] = 4'(w);
    end
  endtask

  task automatic set_w(input int a, input int b, input int w);
    for (int k = 0; k < 4; k++) begin
      if (wt_tab[a][k] != 4'd0 && int'(nbr_tab[a][k]) == b) wt_tab[a][k] = 4'(w);
      if (wt_tab[b][k] != 4'd0 && int'(nbr_tab[b][k]) == a) wt_tab[b][k] = 4'(w);
    end
  endtask

  // true shortest cost; the engine can only report routes cheaper than 255
  function automatic int ref_dist(input int s, input int e);
    int d [N];
    for (int i = 0; i < N; i++) d[i] = 100000;
    d[s] = 0;
    for (int it = 0; it < N; it++)
      for (int u = 0; u < N; u++)
        for (int k = 0; k < 4; k++)
          if (wt_tab[u][k] != 4'd0 && int'(nbr_tab[u][k]) < N &&
              d[u] + int'(wt_tab[u][k]) < d[int'(nbr_tab[u][k])])
            d[int'(nbr_tab[u][k])] = d[u] + int'(wt_tab[u][k]);
    return d[e];
  endfunction

  task automatic request(input int s, input int e);
    @(negedge clk);
    CPU_start = 1'b0;
    repeat (2) @(negedge clk);
    start_point = 5'(s);
    end_point   = 5'(e);
    CPU_start   = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    cyc = 0;
    busy_gap = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (!(path_valid || no_path) && !busy) busy_gap = 1'b1;
    end while (!(path_valid || no_path) && cyc < 3000);
    chk({tag, "_done"}, int'(path_valid || no_path), 1);
  endtask

  task automatic get_node(input int i, output int v);
    @(negedge clk);
    path_idx = 5'(i);
    #1 v = int'(path_node);
  endtask

  task automatic chk_path(input string tag, input int len, input int p0, input int p1,
                          input int p2, input int p3);
    int ex [4];
    int v;
    ex[0] = p0; ex[1] = p1; ex[2] = p2; ex[3] = p3;
    chk({tag, "_len"}, int'(path_len), len);
    for (int i = 0; i < len; i++) begin
      get_node(i, v);
      chk($sformatf("%s_n%0d", tag, i), v, ex[i]);
    end
    get_node(len, v);
    chk({tag, "_past_end"}, v, 0);
  endtask

  initial begin
    int v, d, s, e, a, b, len, cost, bad, pv;
    clr_rom(1'b0);
    add_edge(0, 1, 1); add_edge(1, 2, 1); add_edge(0, 3, 5);
    add_edge(3, 2, 1); add_edge(2, 4, 2);

    #12;
    chk("rst_valid", int'(path_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_nopath", int'(no_path), 0);
    chk("rst_len", int'(path_len), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_slot", int'(rom_slot), 0);
    @(negedge clk);
    rst_n = 1'b1;

    request(0, 4); wait_done("p04");
    chk("p04_busy_gap", int'(busy_gap), 0);
    chk("p04_valid", int'(path_valid), 1);
    chk("p04_nopath", int'(no_path), 0);
    chk("p04_busy_after", int'(busy), 0);
    chk_path("p04", 4, 0, 1, 2, 4);

    set_w(1, 2, 9);
    request(0, 2); wait_done("p02");
    chk_path("p02", 3, 0, 3, 2, 0);
    set_w(1, 2, 1);

    request(5, 0); wait_done("p50");
    chk("p50_nopath", int'(no_path), 1);
    chk("p50_valid", int'(path_valid), 0);
    chk("p50_len", int'(path_len), 0);

    request(31, 0);
    @(negedge clk); chk("s31_nopath_early", int'(no_path), 0);
    @(negedge clk); chk("s31_nopath", int'(no_path), 1);
    chk("s31_busy", int'(busy), 0);

    request(2, 2); wait_done("p22");
    chk("p22_latency", cyc, 62);
    chk_path("p22", 1, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_point = (i == 0) ? 5'd1 : 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("p22_sweep_busy", int'(busy), 0);
      chk("p22_sweep_valid", int'(path_valid), 1);
    end
    chk_path("p22_sweep", 1, 2, 0, 0, 0);

    request(0, 4); wait_done("p04b");
    chk("p04b_valid", int'(path_valid), 1);
    @(negedge clk); end_point = 5'd3;
    @(negedge clk);
    chk("retrig_valid", int'(path_valid), 0);
    chk("retrig_busy", int'(busy), 1);
    wait_done("p03");
    chk_path("p03", 4, 0, 1, 2, 3);

    request(0, 4);
    repeat (40) @(negedge clk);
    chk("scan_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(path_valid), 0);
    chk("arst_len", int'(path_len), 0);
    chk("arst_addr", int'(rom_addr), 0);
    @(negedge clk); CPU_start = 1'b0; rst_n = 1'b1;
    request(0, 4); wait_done("p04c");
    chk_path("p04c", 4, 0, 1, 2, 4);

    request(0, 4);
    repeat (62) @(negedge clk);
    chk("relax_busy", int'(busy), 1);
    CPU_start = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(path_valid), 0);
    repeat (5) @(negedge clk);
    chk("abort_valid_late", int'(path_valid), 0);

    for (int g = 0; g < 6; g++) begin
      clr_rom(1'b1);
      for (int t = 0; t < 40; t++) begin
        a = $urandom_range(0, N - 1);
        b = $urandom_range(0, N - 1);
        if (a != b && edge_w(a, b) == 0) add_edge(a, b, $urandom_range(1, 15));
      end
      for (int r = 0; r < 4; r++) begin
        s = $urandom_range(0, N - 1);
        e = (r == 0) ? s : $urandom_range(0, N - 1);
        request(s, e); wait_done("rnd");
        d = ref_dist(s, e);
        if (d < 255) begin
          chk("rnd_valid", int'(path_valid), 1);
          chk("rnd_nopath", int'(no_path), 0);
          len = int'(path_len);
          cost = 0; bad = 0;
          get_node(0, v);
          chk("rnd_first", v, s);
          pv = v;
          for (int i = 1; i < len; i++) begin
            get_node(i, v);
            if (edge_w(pv, v) == 0) bad++;
            cost += edge_w(pv, v);
            pv = v;
          end
          chk("rnd_last", pv, e);
          chk("rnd_edges", bad, 0);
          chk("rnd_cost", cost, d);
        end else begin
          chk("rnd_nopath", int'(no_path), 1);
          chk("rnd_valid", int'(path_valid), 0);
          chk("rnd_len", int'(path_len), 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dijkstra_path_engine.md
Name: dijkstra_path_engine

Overview:
- Path-planning responder on the planner interface: CPU_start / start_point / end_point.
- Computes a minimum-weight node route over the arena graph using Dijkstra.
- Stores the route in an internal path buffer, readable by the path-follower through an indexed read port.
- Reads graph connectivity from a sibling combinational map ROM (node, slot → neighbour, weight).

Parameters:
- NODES, 30, number of arena nodes; valid ids 0..NODES-1.
- MAX_DEG, 4, neighbour slots per node in the map ROM.
- INF, 8'hFF, distance sentinel for "unreached".

Ports:
- clk_3125KHz  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- CPU_start  input  1  request level; held high by the planner while the route is in use.
- start_point  input  5  source node.
- end_point  input  5  destination node.
- rom_addr  output  5  node whose neighbour list is being read.
- rom_slot  output  2  neighbour slot 0..MAX_DEG-1.
- rom_nbr  input  5  neighbour id, same-cycle combinational response.
- rom_wt  input  4  edge weight; 0 = empty slot.
- path_idx  input  5  read index; 0 = start node.
- path_node  output  5  node at path_idx; combinational from the buffer.
- path_len  output  5  number of nodes in route, start and end inclusive.
- path_valid  output  1  route in buffer is complete and current.
- busy  output  1  computation in progress.
- no_path  output  1  last request unreachable or out of range.

Behaviour:
- Reset (async, rst_n=0): state IDLE; path_valid=0, busy=0, no_path=0, path_len=0, rom_addr=0, rom_slot=0; dist/prev/visited arrays cleared.
- Request trigger, sampled on clk_3125KHz:
  - rising edge of CPU_start, or
  - end_point differs from the latched end while CPU_start=1.
- start_point changes alone never retrigger; the planner is allowed to track the current node on start_point.
- On trigger: latch start/end; path_valid=0, no_path=0, busy=1.
- State sequence:
  - INIT: NODES cycles; dist[i]=INF, prev[i]=i, visited[i]=0; then dist[start]=0.
  - SCAN: NODES cycles; select the unvisited node u with minimum dist. Ties go to the lower index.
  - SCAN exits:
    - if min dist == INF, go to FAIL;
    - if u == end, go to TRACE;
    - otherwise set visited[u]=1 and go to RELAX.
  - RELAX: MAX_DEG cycles; rom_addr=u, rom_slot=k.
    - If rom_wt!=0, the neighbour v is unvisited, and dist[u]+rom_wt < dist[v], then dist[v] and prev[v] are updated.
    - The sum is computed 9-bit; a sum >= INF never updates.
    - Then return to SCAN.
  - TRACE: one node per cycle from end following prev until start; each node is written to buf[n] with n incrementing.
    - path_len = n+1.
    - path_node = buf[path_len-1-path_idx]; path_idx >= path_len returns 0.
    - On finishing: busy=0, path_valid=1, go to HOLD.
  - FAIL: no_path=1, busy=0, path_len=0, go to HOLD.
  - HOLD: outputs stable while CPU_start=1. CPU_start=0 → path_valid=0, go to IDLE.
- Boundaries:
  - start==end: path_len=1, path_node(0)=start, path_valid set after INIT plus one SCAN pass.
  - start or end >= NODES: FAIL directly from IDLE on the next cycle.
  - CPU_start falling during INIT/SCAN/RELAX/TRACE: abort to IDLE next cycle; busy=0, path_valid=0, buffer contents undefined.
  - Trigger during busy (end_point change): restart at INIT with the new endpoints.
  - Worst-case latency: NODES + NODES*(NODES+MAX_DEG) + NODES cycles = 1080 at defaults, about 0.35 ms.

Test Plan:
- Bench ROM edges: 0-1 w1, 1-2 w1, 0-3 w5, 3-2 w1, 2-4 w2; node 5 isolated. All others empty.
- CPU_start 0→1, start=0, end=4 → path_valid=1; path_len=4; path nodes 0,1,2,4; no_path=0; busy high throughout compute.
- Change weight 1-2 to w9 in ROM, request 0→2 → path 0,3,2; path_len=3 (cost 6 beats 10).
- start=5, end=0 → no_path=1, path_valid=0, path_len=0; start=31 → no_path=1 one cycle after the trigger.
- start=end=2 → path_len=1, path_node(0)=2; then sweep start_point 2→1 with CPU_start high → no recompute, outputs unchanged.
- Path valid for 0→4, then end_point changed to 3 while CPU_start=1 → path_valid drops, busy=1, then path 0,3 (cost 5 vs 0-1-2-3 cost 3 → expected 0,1,2,3, path_len=4).
- rst_n pulsed low mid-SCAN → all outputs return to reset values immediately (async); a new CPU_start rising edge computes correctly. CPU_start dropped mid-RELAX → IDLE next cycle, path_valid stays 0.
